// File: rtl/digit_recoder_seq_if.sv
// Valid/ready bundle for the signed-digit carry propagator:
// input vector channel plus result channel.
interface digit_recoder_seq_if #(
    parameter int NDIG = 64,
    parameter int DW   = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [NDIG*DW-1:0] in_data;
    logic               in_mode;
    logic               out_valid;
    logic               out_ready;
    logic [NDIG*DW-1:0] out_data;
    logic               out_ovf;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/digit_recoder_seq.sv
// Sequential signed-digit carry propagator: ripples window carries
// from digit 0 to digit NDIG-1, LANES digits per RUN cycle.
module digit_recoder_seq #(
    parameter int NDIG  = 64,
    parameter int DW    = 8,
    parameter int WIN   = 4,
    parameter int LANES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    digit_recoder_seq_if.slave bus
);
    localparam int AW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int SW = DW + 2;
    localparam logic [AW-1:0] LAST_IDX = AW'(NDIG - LANES);
    localparam logic [AW-1:0] TOP      = AW'(NDIG - 1);
    localparam logic signed [SW-1:0] HALF = SW'(2 ** (WIN - 1));

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [NDIG-1:0][DW-1:0] buf_q, buf_d;
    logic [DW-1:0]           carry_q, carry_d;
    logic [AW-1:0]           idx_q, idx_d;
    logic                    mode_q, mode_d;
    logic                    ovf_q, ovf_d;
    logic                    accept;
    logic                    last_grp;

    assign accept   = (state_q == IDLE) && bus.in_valid;
    assign last_grp = (idx_q == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            buf_q   <= '0;
            carry_q <= '0;
            idx_q   <= '0;
            mode_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (last_grp) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Packed digit i lives at buf[NDIG-1-i], matching the port packing.
    always_comb begin
        logic signed [SW-1:0] s;
        logic signed [SW-1:0] t;
        logic signed [SW-1:0] c;
        logic signed [SW-1:0] r;
        logic [AW-1:0]        j;
        logic [DW-1:0]        e;
        logic [DW-1:0]        cin;
        buf_d   = buf_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        ovf_d   = ovf_q;
        s       = '0;
        t       = '0;
        c       = '0;
        r       = '0;
        j       = '0;
        e       = '0;
        cin     = carry_q;
        if (accept) begin
            buf_d   = bus.in_data;
            mode_d  = bus.in_mode;
            carry_d = '0;
            idx_d   = '0;
            ovf_d   = 1'b0;
        end else if (state_q == RUN) begin
            for (int l = 0; l < LANES; l++) begin
                j = idx_q + AW'(l);
                e = buf_q[TOP - j];
                s = {{2{e[DW-1]}}, e} + {{2{cin[DW-1]}}, cin};
                if (j == TOP) begin
                    buf_d[TOP - j] = s[DW-1:0];
                    ovf_d = (s[SW-1:DW-1] != {(SW-DW+1){s[DW-1]}});
                end else begin
                    t   = mode_q ? s : s + HALF;
                    c   = t >>> WIN;
                    r   = s - (c <<< WIN);
                    buf_d[TOP - j] = r[DW-1:0];
                    cin = c[DW-1:0];
                end
            end
            carry_d = cin;
            idx_d   = last_grp ? '0 : idx_q + AW'(LANES);
        end
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.out_data  = buf_q;
        bus.out_ovf   = ovf_q;
    end
endmodule
